// File: rtl/gate_chk_pkg.sv
// ============================================================================
// Module      : gate_chk_pkg
// Description : Shared types and truth table for the gate vector checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Indexed by {a,b}; each entry is {or, and, xor, xnor}.
    localparam logic [3:0] EXP_TABLE [0:3] = '{4'b0001, 4'b1010, 4'b1010, 4'b1101};

endpackage

`default_nettype wire

// File: rtl/gate_expect.sv
// ============================================================================
// Module      : gate_expect
// Description : Combinational reference: a,b -> expected {or,and,xor,xnor}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_expect
    import gate_chk_pkg::*;
(
    input  logic       a,
    input  logic       b,
    output logic [3:0] exp_vec
);

    logic [1:0] w_idx;

    assign w_idx   = {a, b};
    assign exp_vec = EXP_TABLE[w_idx];

endmodule

`default_nettype wire

// File: rtl/gate_vector_checker.sv
// ============================================================================
// Module      : gate_vector_checker
// Description : Sweeps a,b over 00..11, compares gate outputs to the truth
//               table and reports a saturating error count and pass flag.
//               Optional macro GVC_FIRST_FAIL_EN adds first-mismatch capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_vector_checker
    import gate_chk_pkg::*;
#(
    parameter int DWELL_CYCLES = 100,
    parameter int ERR_W        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             cor,
    input  logic             cand,
    input  logic             cxor,
    input  logic             cxnor,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       vec_idx
`ifdef GVC_FIRST_FAIL_EN
    ,
    output logic             first_fail_vld,
    output logic [1:0]       first_fail_vec,
    output logic [3:0]       first_fail_got
`endif
);

    localparam int               DW_W           = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW_W-1:0]  C_DWELL_RELOAD = DW_W'(DWELL_CYCLES - 1);
    localparam logic [ERR_W-1:0] C_ERR_MAX      = '1;
    localparam logic [1:0]       C_LAST_VEC     = 2'd3;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_vec;
    logic [DW_W-1:0]  r_dwell;
    logic [ERR_W-1:0] r_err;
    logic             r_pass;

    logic             w_launch;
    logic             w_sample;
    logic [3:0]       w_exp;
    logic [3:0]       w_got;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_nxt;

    gate_expect u_expect (
        .a       (r_vec[1]),
        .b       (r_vec[0]),
        .exp_vec (w_exp)
    );

    assign w_got      = {cor, cand, cxor, cxnor};
    assign w_mismatch = (w_got != w_exp);
    assign w_err_nxt  = (w_sample && w_mismatch && (r_err != C_ERR_MAX))
                        ? r_err + ERR_W'(1) : r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_sample    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                busy = 1'b1;
                if (r_dwell == '0) begin
                    w_sample = 1'b1;
                    if (r_vec == C_LAST_VEC) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The last compare both updates err_cnt and decides pass in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec   <= 2'd0;
            r_dwell <= '0;
            r_err   <= '0;
            r_pass  <= 1'b0;
        end else if (w_launch) begin
            r_vec   <= 2'd0;
            r_dwell <= C_DWELL_RELOAD;
            r_err   <= '0;
            r_pass  <= 1'b0;
        end else if (w_sample) begin
            r_err <= w_err_nxt;
            if (r_vec != C_LAST_VEC) begin
                r_vec   <= r_vec + 2'd1;
                r_dwell <= C_DWELL_RELOAD;
            end else begin
                r_pass <= (w_err_nxt == '0);
            end
        end else if (r_state == ST_DRIVE) begin
            r_dwell <= r_dwell - DW_W'(1);
        end
    end

`ifdef GVC_FIRST_FAIL_EN
    logic       r_ff_vld;
    logic [1:0] r_ff_vec;
    logic [3:0] r_ff_got;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff_vld <= 1'b0;
            r_ff_vec <= 2'd0;
            r_ff_got <= 4'd0;
        end else if (w_launch) begin
            r_ff_vld <= 1'b0;
            r_ff_vec <= 2'd0;
            r_ff_got <= 4'd0;
        end else if (w_sample && w_mismatch && !r_ff_vld) begin
            r_ff_vld <= 1'b1;
            r_ff_vec <= r_vec;
            r_ff_got <= w_got;
        end
    end

    assign first_fail_vld = r_ff_vld;
    assign first_fail_vec = r_ff_vec;
    assign first_fail_got = r_ff_got;
`endif

    assign a       = r_vec[1];
    assign b       = r_vec[0];
    assign vec_idx = r_vec;
    assign err_cnt = r_err;
    assign pass    = r_pass;

endmodule

`default_nettype wire

// File: tb/tb_gate_vector_checker.sv
// ============================================================================
// Module      : tb_gate_vector_checker
// Description : Directed self-checking bench for gate_vector_checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_vector_checker;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start_s = 1'b0;
    logic [1:0] fault = 2'd0;

    logic       a, b, busy, done, pass;
    logic [2:0] err_cnt;
    logic [1:0] vec_idx;
    logic       g_or, g_and, g_xor, g_xnor;

    logic       s_a, s_b, s_busy, s_done, s_pass;
    logic [0:0] s_err_cnt;
    logic [1:0] s_vec_idx;
    logic       s_or, s_and, s_xor, s_xnor;

`ifdef GVC_FIRST_FAIL_EN
    logic       ff_vld, s_ff_vld;
    logic [1:0] ff_vec, s_ff_vec;
    logic [3:0] ff_got, s_ff_got;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Gate model: 0 = good, 1 = cand stuck at 0, 2 = all outputs inverted.
    always_comb begin
        g_or   = a | b;
        g_and  = a & b;
        g_xor  = a ^ b;
        g_xnor = ~(a ^ b);
        if (fault == 2'd1) g_and = 1'b0;
        if (fault == 2'd2) begin
            g_or   = ~(a | b);
            g_and  = ~(a & b);
            g_xor  = a ^ b ^ 1'b1;
            g_xnor = a ^ b;
        end
    end

    assign s_or   = ~(s_a | s_b);
    assign s_and  = ~(s_a & s_b);
    assign s_xor  = ~(s_a ^ s_b);
    assign s_xnor = s_a ^ s_b;

    gate_vector_checker #(.DWELL_CYCLES(D), .ERR_W(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .cor(g_or), .cand(g_and), .cxor(g_xor), .cxnor(g_xnor),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .vec_idx(vec_idx)
`ifdef GVC_FIRST_FAIL_EN
        , .first_fail_vld(ff_vld), .first_fail_vec(ff_vec), .first_fail_got(ff_got)
`endif
    );

    gate_vector_checker #(.DWELL_CYCLES(D), .ERR_W(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_s), .a(s_a), .b(s_b),
        .cor(s_or), .cand(s_and), .cxor(s_xor), .cxnor(s_xnor),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err_cnt), .vec_idx(s_vec_idx)
`ifdef GVC_FIRST_FAIL_EN
        , .first_fail_vld(s_ff_vld), .first_fail_vec(s_ff_vec), .first_fail_got(s_ff_got)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edges from the current point until done is seen; -1 if it never comes.
    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (done === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({a, b, busy, done, pass, err_cnt, vec_idx} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_state: got %b expected %b",
                     {a, b, busy, done, pass, err_cnt, vec_idx}, 10'd0);
        end
        n_cmp++;
        if ({s_busy, s_done, s_pass, s_err_cnt, s_vec_idx} !== 6'd0) begin
            n_err++;
            $display("FAIL reset_state_sat: got %b expected %b",
                     {s_busy, s_done, s_pass, s_err_cnt, s_vec_idx}, 6'd0);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_good_sweep();
        logic [1:0] ev;
        logic       eb, ed;
        int         bad;
        fault = 2'd0;
        bad   = 0;
        launch();
        for (int k = 0; k <= 4 * D + 1; k++) begin
            if (k > 0) tick();
            eb = (k < 4 * D);
            ed = (k == 4 * D);
            ev = (k < 4 * D) ? 2'(k / D) : 2'd3;
            if ({busy, done, vec_idx, a, b} !== {eb, ed, ev, ev}) bad++;
            if (bad == 1 && {busy, done, vec_idx, a, b} !== {eb, ed, ev, ev}) begin
                $display("FAIL good_trajectory k=%0d: got %b expected %b",
                         k, {busy, done, vec_idx, a, b}, {eb, ed, ev, ev});
            end
        end
        n_cmp++;
        if (bad != 0) n_err++;
        n_cmp++;
        if ({pass, err_cnt} !== {1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL good_result: got pass=%b err=%0d expected pass=1 err=0", pass, err_cnt);
        end
    endtask

    task automatic test_cand_stuck();
        int c;
        fault = 2'd1;
        launch();
        wait_done(c);
        n_cmp++;
        if (c !== 4 * D) begin
            n_err++;
            $display("FAIL cand_done_time: got %0d expected %0d", c, 4 * D);
        end
        n_cmp++;
        if ({pass, err_cnt} !== {1'b0, 3'd1}) begin
            n_err++;
            $display("FAIL cand_result: got pass=%b err=%0d expected pass=0 err=1", pass, err_cnt);
        end
`ifdef GVC_FIRST_FAIL_EN
        n_cmp++;
        if ({ff_vld, ff_vec, ff_got} !== {1'b1, 2'd3, 4'b1001}) begin
            n_err++;
            $display("FAIL cand_first_fail: got %b expected %b", {ff_vld, ff_vec, ff_got}, 7'b1111001);
        end
`endif
        tick();
        fault = 2'd0;
    endtask

    task automatic test_all_inverted();
        int c;
        fault = 2'd2;
        launch();
        wait_done(c);
        n_cmp++;
        if ({pass, err_cnt} !== {1'b0, 3'd4}) begin
            n_err++;
            $display("FAIL inverted_result: got pass=%b err=%0d expected pass=0 err=4", pass, err_cnt);
        end
`ifdef GVC_FIRST_FAIL_EN
        n_cmp++;
        if ({ff_vld, ff_vec, ff_got} !== {1'b1, 2'd0, 4'b1110}) begin
            n_err++;
            $display("FAIL inverted_first_fail: got %b expected %b", {ff_vld, ff_vec, ff_got}, 7'b1001110);
        end
`endif
        tick();
        fault = 2'd0;
    endtask

    task automatic test_saturate();
        int c;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        c = -1;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (s_done === 1'b1) begin
                c = i;
                break;
            end
        end
        n_cmp++;
        if (c !== 4 * D) begin
            n_err++;
            $display("FAIL sat_done_time: got %0d expected %0d", c, 4 * D);
        end
        n_cmp++;
        if ({s_pass, s_err_cnt} !== {1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL sat_result: got pass=%b err=%0d expected pass=0 err=1", s_pass, s_err_cnt);
        end
`ifdef GVC_FIRST_FAIL_EN
        n_cmp++;
        if ({s_ff_vld, s_ff_vec, s_ff_got} !== {1'b1, 2'd0, 4'b1110}) begin
            n_err++;
            $display("FAIL sat_first_fail: got %b expected %b", {s_ff_vld, s_ff_vec, s_ff_got}, 7'b1001110);
        end
`endif
        tick();
    endtask

    task automatic test_start_ignored();
        int c;
        fault = 2'd0;
        launch();
        c = -1;
        for (int i = 1; i <= 200; i++) begin
            start = (i == 6 || i == 10);
            tick();
            if (done === 1'b1) begin
                c = i;
                break;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (c !== 4 * D) begin
            n_err++;
            $display("FAIL restart_ignored_time: got %0d expected %0d", c, 4 * D);
        end
        // A start seen while in DONE must not launch a new sweep.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if ({busy, done, pass} !== 3'b001) begin
            n_err++;
            $display("FAIL start_in_done: got busy/done/pass=%b expected 001", {busy, done, pass});
        end
    endtask

    task automatic test_reset_mid();
        int c;
        fault = 2'd0;
        launch();
        for (int i = 0; i < 2 * D + 1; i++) tick();
        n_cmp++;
        if (vec_idx !== 2'd2) begin
            n_err++;
            $display("FAIL mid_vec_before_reset: got %0d expected 2", vec_idx);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a, b, busy, done, pass, err_cnt, vec_idx} !== 10'd0) begin
            n_err++;
            $display("FAIL async_reset: got %b expected %b",
                     {a, b, busy, done, pass, err_cnt, vec_idx}, 10'd0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_no_done: got busy/done=%b expected 00", {busy, done});
        end
        launch();
        wait_done(c);
        n_cmp++;
        if (c !== 4 * D || {pass, err_cnt} !== {1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL post_reset_sweep: got cycles=%0d pass=%b err=%0d expected %0d 1 0",
                     c, pass, err_cnt, 4 * D);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        fault = 2'd0;
        start = 1'b1;
        tick();
        wait_done(c1);
        wait_done(c2);
        start = 1'b0;
        n_cmp++;
        if (c1 !== 4 * D) begin
            n_err++;
            $display("FAIL b2b_first_done: got %0d expected %0d", c1, 4 * D);
        end
        n_cmp++;
        if (c2 !== 4 * D + 2) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d expected %0d", c2, 4 * D + 2);
        end
        tick();
        tick();
        n_cmp++;
        if ({busy, done, pass} !== 3'b001) begin
            n_err++;
            $display("FAIL b2b_stop: got busy/done/pass=%b expected 001", {busy, done, pass});
        end
    endtask

    initial begin
        test_reset();
        test_good_sweep();
        test_cand_stuck();
        test_all_inverted();
        test_saturate();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
